// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW bundle packer: scalar instruction layout,
// opcodes and register-use helpers.
package vliw_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_MOV  = 3'd4;

  localparam int OP_LSB    = 0;
  localparam int DEST_LSB  = 3;
  localparam int SRC1_LSB  = 6;
  localparam int SRC2_LSB  = 9;
  localparam int IMM_LSB   = 12;
  localparam int VALID_BIT = 31;

  typedef struct packed {
    logic        valid;
    logic [18:0] imm;
    logic [2:0]  src2;
    logic [2:0]  src1;
    logic [2:0]  dest;
    logic [2:0]  op;
  } vliw_instr_t;

  function automatic logic reads_src1(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_ADDI);
  endfunction

  function automatic logic reads_src2(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

  function automatic logic is_placeable(input vliw_instr_t i);
    return i.valid && ((i.op == OP_ADD) || (i.op == OP_MUL) ||
                       (i.op == OP_ADDI) || (i.op == OP_MOV));
  endfunction

endpackage

// File: rtl/vliw_hazard_check.sv
// Flags an intra-bundle RAW/WAW hazard between an incoming instruction and the
// set of destinations already written by the open bundle.
module vliw_hazard_check
  import vliw_pkg::*;
(
  input  vliw_instr_t instr,
  input  logic [7:0]  wmask,
  output logic        conflict
);

  logic unused_bits;
  assign unused_bits = ^{instr.valid, instr.imm};

  assign conflict = wmask[instr.dest] ||
                    (reads_src1(instr.op) && wmask[instr.src1]) ||
                    (reads_src2(instr.op) && wmask[instr.src2]);

endmodule

// File: rtl/vliw_bundle_packer.sv
// Packs an in-order scalar instruction stream into hazard-free VLIW bundles.
// Optional idle-timeout close is enabled by defining VLIW_PACK_TIMEOUT_EN.
module vliw_bundle_packer
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [32*NUM_SLOTS-1:0] out_bundle,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0][31:0] acc, acc_p, acc_n, close_bundle;
  logic [CW-1:0]              cnt, cnt_p, cnt_n;
  logic [7:0]                 wmask, wmask_p, wmask_n;
  logic                       flush_pend, flush_pend_n;
  logic                       out_free, accept, place, conflict, do_close, timeout_fire;
  vliw_instr_t                ins;

  assign ins      = vliw_instr_t'(in_instr);
  assign out_free = !out_valid || out_ready;
  assign in_ready = !rst && out_free;
  assign accept   = in_valid && in_ready;
  assign place    = accept && is_placeable(ins);
  assign busy     = (cnt != '0) || flush_pend;

  vliw_hazard_check u_hazard (
    .instr    (ins),
    .wmask    (wmask),
    .conflict (conflict)
  );

`ifdef VLIW_PACK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_cnt;

  // The edge that would bring the count to TIMEOUT_CYC closes the bundle.
  assign timeout_fire = !accept && (cnt != '0) && out_free &&
                        (idle_cnt >= IW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         idle_cnt <= '0;
    else if (accept || do_close)                     idle_cnt <= '0;
    else if (cnt != '0 && idle_cnt != IW'(TIMEOUT_CYC)) idle_cnt <= idle_cnt + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    // Placement of a non-conflicting instruction into the open bundle.
    acc_p   = acc;
    cnt_p   = cnt;
    wmask_p = wmask;
    if (place && !conflict) begin
      for (int s = 0; s < NUM_SLOTS; s++)
        if (cnt == CW'(s)) acc_p[s] = in_instr;
      cnt_p             = cnt + 1'b1;
      wmask_p[ins.dest] = 1'b1;
    end

    acc_n        = acc_p;
    cnt_n        = cnt_p;
    wmask_n      = wmask_p;
    flush_pend_n = flush_pend;
    do_close     = 1'b0;
    close_bundle = acc_p;

    if (place && conflict) begin
      // Old bundle leaves; a flush on this edge would need a second close.
      do_close        = 1'b1;
      close_bundle    = acc;
      acc_n           = '0;
      acc_n[0]        = in_instr;
      cnt_n           = CW'(1);
      wmask_n         = '0;
      wmask_n[ins.dest] = 1'b1;
      flush_pend_n    = flush;
    end else if (cnt_p != '0 && (cnt_p == CW'(NUM_SLOTS) ||
                 (out_free && (flush || flush_pend)) || timeout_fire)) begin
      do_close     = 1'b1;
      acc_n        = '0;
      cnt_n        = '0;
      wmask_n      = '0;
      flush_pend_n = 1'b0;
    end else if (flush && cnt_p != '0) begin
      flush_pend_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      wmask      <= '0;
      flush_pend <= 1'b0;
    end else begin
      acc        <= acc_n;
      cnt        <= cnt_n;
      wmask      <= wmask_n;
      flush_pend <= flush_pend_n;
    end
  end

  // Every close happens with the output free, so it can always overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_bundle <= '0;
    end else if (do_close) begin
      out_valid  <= 1'b1;
      out_bundle <= close_bundle;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Self-checking bench for vliw_bundle_packer: directed vector table, multi-cycle
// corner sequences and a randomized run against a queue-based reference model.
module tb_vliw_bundle_packer;

  logic         clk, rst, in_valid, flush, out_ready;
  logic [31:0]  in_instr;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_bundle;

  int n_tot  = 0;
  int n_pass = 0;

  vliw_bundle_packer #(.NUM_SLOTS(4), .TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_bundle (out_bundle),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [31:0]  ins;
    logic         fl;
    logic         ordy;
    logic         ev;
    logic [127:0] eb;
    logic         ebusy;
  } vec_t;

  vec_t tbl[16];

  // Reference model state: open bundle as a queue of instructions.
  logic [31:0]  m_q[$];
  logic         m_ov, m_pend;
  logic [127:0] m_b;
  int           m_idle;

  function automatic logic [31:0] mk(input int op, input int d, input int s1, input int s2, input int imm);
    return {1'b1, 19'(imm), 3'(s2), 3'(s1), 3'(d), 3'(op)};
  endfunction

  function automatic logic [127:0] bnd(input logic [31:0] s0, input logic [31:0] s1,
                                       input logic [31:0] s2, input logic [31:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic fl, input logic ordy);
    in_valid  = iv;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_emit();
    logic [127:0] r;
    r = '0;
    foreach (m_q[k]) r[32*k +: 32] = m_q[k];
    m_b  = r;
    m_ov = 1'b1;
    m_q.delete();
  endtask

  task automatic model_step(input logic iv, input logic [31:0] ins, input logic fl, input logic ordy);
    logic free, acc, closed, conf, plc, tmo;
    logic [2:0] op, d, a, b;
    int pre_size;
    free     = !m_ov || ordy;
    acc      = iv && free;
    closed   = 1'b0;
    pre_size = m_q.size();
    if (m_ov && ordy) m_ov = 1'b0;
    op = ins[2:0]; d = ins[5:3]; a = ins[8:6]; b = ins[11:9];
    plc = acc && ins[31] && (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4);
    if (plc) begin
      conf = 1'b0;
      foreach (m_q[k])
        if (m_q[k][5:3] == d || (op != 3'd4 && m_q[k][5:3] == a) ||
            ((op == 3'd0 || op == 3'd1) && m_q[k][5:3] == b)) conf = 1'b1;
      if (conf) begin
        model_emit(); closed = 1'b1;
        m_q.push_back(ins);
        m_pend = fl;
      end else begin
        m_q.push_back(ins);
        if (m_q.size() == 4 || fl || m_pend) begin
          model_emit(); closed = 1'b1; m_pend = 1'b0;
        end
      end
    end else if (m_q.size() > 0) begin
`ifdef VLIW_PACK_TIMEOUT_EN
      tmo = !acc && (m_idle + 1 >= 8);
`else
      tmo = 1'b0;
`endif
      if (free && (fl || m_pend || tmo)) begin
        model_emit(); closed = 1'b1; m_pend = 1'b0;
      end else if (fl) m_pend = 1'b1;
    end
    if (acc || closed) m_idle = 0;
    else if (pre_size > 0 && m_idle < 8) m_idle++;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_bundle", out_bundle, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    m_q.delete(); m_ov = 1'b0; m_pend = 1'b0; m_idle = 0; m_b = '0;
  endtask

  initial begin
    logic [31:0] m1, m2, m3, m4, m5, add2, mov3, addi3, add4, p0, ri;
    logic [127:0] pb, b1, b2;
    logic iv, fl, ordy;

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0;
    #2;
    do_reset();
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    m1 = mk(4,1,0,0,1); m2 = mk(4,2,0,0,2); m3 = mk(4,3,0,0,3); m4 = mk(4,4,0,0,4);
    m5 = mk(4,1,0,0,5); add2 = mk(0,2,1,1,0);
    mov3 = mk(4,3,0,0,7); addi3 = mk(2,3,0,0,1); add4 = mk(0,4,5,6,0);
    p0 = mk(4,1,0,0,9); p0[31] = 1'b0;

    // ---- directed table ----
    tbl[0]  = '{1'b1, m1,    1'b0, 1'b1, 1'b0, 128'h0, 1'b1};
    tbl[1]  = '{1'b1, m2,    1'b0, 1'b1, 1'b0, 128'h0, 1'b1};
    tbl[2]  = '{1'b1, m3,    1'b0, 1'b1, 1'b0, 128'h0, 1'b1};
    tbl[3]  = '{1'b1, m4,    1'b0, 1'b1, 1'b1, bnd(m1,m2,m3,m4), 1'b0};
    tbl[4]  = '{1'b1, m5,    1'b0, 1'b1, 1'b0, 128'h0, 1'b1};
    tbl[5]  = '{1'b1, add2,  1'b0, 1'b1, 1'b1, bnd(m5,0,0,0), 1'b1};
    tbl[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, bnd(add2,0,0,0), 1'b0};
    tbl[7]  = '{1'b1, mov3,  1'b0, 1'b1, 1'b0, 128'h0, 1'b1};
    tbl[8]  = '{1'b1, addi3, 1'b0, 1'b1, 1'b1, bnd(mov3,0,0,0), 1'b1};
    tbl[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, bnd(addi3,0,0,0), 1'b0};
    tbl[10] = '{1'b1, mov3,  1'b0, 1'b1, 1'b0, 128'h0, 1'b1};
    tbl[11] = '{1'b1, add4,  1'b0, 1'b1, 1'b0, 128'h0, 1'b1};
    tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, bnd(mov3,add4,0,0), 1'b0};
    tbl[13] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
    tbl[14] = '{1'b1, p0,    1'b0, 1'b1, 1'b0, 128'h0, 1'b0};
    tbl[15] = '{1'b1, mk(3,1,0,0,0), 1'b0, 1'b1, 1'b0, 128'h0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].iv, tbl[i].ins, tbl[i].fl, tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].ebusy));
      if (tbl[i].ev) chk($sformatf("tbl%0d_bundle", i), out_bundle, tbl[i].eb);
    end

    // ---- backpressure: stalled full bundle, then 8 queued instrs ----
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, mk(4,i,0,0,i+1), 1'b0, 1'b0);
    pb = bnd(mk(4,0,0,0,1), mk(4,1,0,0,2), mk(4,2,0,0,3), mk(4,3,0,0,4));
    chk("bp_first_valid", 128'(out_valid), 128'(1));
    chk("bp_first_bundle", out_bundle, pb);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_instr = mk(4,0,0,0,20); out_ready = 1'b0;
      #1;
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      @(posedge clk); @(negedge clk);
      chk("bp_stable", out_bundle, pb);
    end
    b1 = bnd(mk(4,0,0,0,20), mk(4,1,0,0,21), mk(4,2,0,0,22), mk(4,3,0,0,23));
    b2 = bnd(mk(4,4,0,0,24), mk(4,5,0,0,25), mk(4,6,0,0,26), mk(4,7,0,0,27));
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, mk(4,k,0,0,20+k), 1'b0, 1'b1);
      chk($sformatf("bp_q%0d_valid", k), 128'(out_valid), 128'(k == 3 || k == 7));
      if (k == 3) chk("bp_bundle_a", out_bundle, b1);
      if (k == 7) chk("bp_bundle_b", out_bundle, b2);
    end

    // ---- flush while output stalled ----
    do_reset();
    cyc(1'b1, m5, 1'b0, 1'b0);
    cyc(1'b1, add2, 1'b0, 1'b0);
    chk("fs_conflict_bundle", out_bundle, bnd(m5,0,0,0));
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fs_pend_busy", 128'(busy), 128'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("fs_stall_bundle", out_bundle, bnd(m5,0,0,0));
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("fs_close_valid", 128'(out_valid), 128'(1));
    chk("fs_close_bundle", out_bundle, bnd(add2,0,0,0));
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("fs_drain_valid", 128'(out_valid), 128'(0));
    chk("fs_drain_busy", 128'(busy), 128'(0));

    // ---- idle behaviour ----
    do_reset();
    cyc(1'b1, m1, 1'b0, 1'b1);
`ifdef VLIW_PACK_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      chk($sformatf("tmo_idle%0d_valid", i), 128'(out_valid), 128'(i == 8));
      if (i == 8) chk("tmo_bundle", out_bundle, bnd(m1,0,0,0));
    end
`else
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      chk($sformatf("idle%0d_valid", i), 128'(out_valid), 128'(0));
    end
    chk("idle_busy", 128'(busy), 128'(1));
`endif

    // ---- reset mid-pack ----
    do_reset();
    cyc(1'b1, m1, 1'b0, 1'b1);
    cyc(1'b1, m2, 1'b0, 1'b1);
    chk("mid_busy", 128'(busy), 128'(1));
    do_reset();
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("mid_after_valid", 128'(out_valid), 128'(0));
    chk("mid_after_busy", 128'(busy), 128'(0));

    // ---- randomized run against reference model ----
    do_reset();
    for (int c = 0; c < 800; c++) begin
      iv   = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 11) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      ri   = $urandom;
      ri[31] = ($urandom_range(0, 7) != 0);
      in_valid = iv; in_instr = ri; flush = fl; out_ready = ordy;
      #1;
      chk("rnd_in_ready", 128'(in_ready), 128'(!m_ov || ordy));
      @(posedge clk);
      model_step(iv, ri, fl, ordy);
      @(negedge clk);
      chk("rnd_out_valid", 128'(out_valid), 128'(m_ov));
      chk("rnd_busy", 128'(busy), 128'((m_q.size() > 0) || m_pend));
      if (m_ov) chk("rnd_bundle", out_bundle, m_b);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
